// File: rtl/plane_setup_sched.sv
// plane_setup_sched: sequences the shared plane-equation setup unit, then walks one tile.
// Optional build macro PSS_PERF_EN adds perf_tiles / perf_stalls counter outputs.
module plane_setup_sched #(
    parameter int  NUM_ATTR  = 4,
    parameter int  SETUP_LAT = 3,
    parameter int  TILE_W    = 32,
    parameter int  TILE_H    = 32,
    localparam int ATTR_W    = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tri_valid,
    output logic              tri_ready,
    input  logic [10:0]       tile_x_base,
    input  logic [10:0]       tile_y_base,
    input  logic              abort,
    output logic [ATTR_W-1:0] attr_sel,
    output logic              coef_we,
    output logic [ATTR_W-1:0] coef_idx,
    output logic [10:0]       x_ps,
    output logic [10:0]       y_ps,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              span_last,
`ifdef PSS_PERF_EN
    output logic [31:0]       perf_tiles,
    output logic [31:0]       perf_stalls,
`endif
    output logic              tile_done
);

    localparam int LAT_W = (SETUP_LAT > 1) ? $clog2(SETUP_LAT) : 1;
    localparam int XW    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int YW    = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [LAT_W-1:0]  LAT_MAX   = LAT_W'(SETUP_LAT - 1);
    localparam logic [ATTR_W-1:0] ATTR_LAST = ATTR_W'(NUM_ATTR - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(TILE_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(TILE_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ROW_PREP,
        S_WALK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              rdy_q;
    logic [10:0]       x_base_q, y_base_q;
    logic [ATTR_W-1:0] attr_q;
    logic [LAT_W-1:0]  lat_q;
    logic [XW-1:0]     xcnt_q;
    logic [YW-1:0]     ycnt_q;

    logic accept;
    logic lat_zero;
    logic x_last;
    logic y_last;

    assign accept   = (state_q == S_IDLE) && tri_valid && rdy_q;
    assign lat_zero = (lat_q == '0);
    assign x_last   = (xcnt_q == X_LAST);
    assign y_last   = (ycnt_q == Y_LAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins from any busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (lat_zero && attr_q == ATTR_LAST) state_d = S_ROW_PREP;
            end
            S_ROW_PREP: begin
                state_d = S_WALK;
            end
            S_WALK: begin
                if (px_ready && x_last) begin
                    state_d = y_last ? S_DONE : S_ROW_PREP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Bases, attribute select, latency and tile walk counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_q    <= 1'b0;
            x_base_q <= '0;
            y_base_q <= '0;
            attr_q   <= '0;
            lat_q    <= '0;
            xcnt_q   <= '0;
            ycnt_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                x_base_q <= tile_x_base;
                y_base_q <= tile_y_base;
                attr_q   <= '0;
                lat_q    <= LAT_MAX;
                xcnt_q   <= '0;
                ycnt_q   <= '0;
            end else if (state_q == S_SETUP && !abort) begin
                if (!lat_zero) begin
                    lat_q <= lat_q - LAT_W'(1);
                end else if (attr_q != ATTR_LAST) begin
                    attr_q <= attr_q + ATTR_W'(1);
                    lat_q  <= LAT_MAX;
                end
            end else if (state_q == S_WALK && px_ready) begin
                if (!x_last) begin
                    xcnt_q <= xcnt_q + XW'(1);
                end else if (!y_last) begin
                    xcnt_q <= '0;
                    ycnt_q <= ycnt_q + YW'(1);
                end
            end
        end
    end

    // Outputs decoded from state and counters
    always_comb begin
        tri_ready = (state_q == S_IDLE) && rdy_q;
        attr_sel  = attr_q;
        coef_we   = (state_q == S_SETUP) && lat_zero && !abort;
        coef_idx  = attr_q;
        x_ps      = x_base_q + 11'(xcnt_q);
        y_ps      = y_base_q + 11'(ycnt_q);
        px_valid  = (state_q == S_WALK);
        span_last = (state_q == S_WALK) && x_last;
        tile_done = (state_q == S_DONE) && !abort;
    end

`ifdef PSS_PERF_EN
    logic [31:0] perf_tiles_q;
    logic [31:0] perf_stalls_q;

    // Free-running tile and backpressure counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_tiles_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (tile_done) perf_tiles_q <= perf_tiles_q + 32'd1;
            if (px_valid && !px_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_tiles  = perf_tiles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_plane_setup_sched.sv
// tb_plane_setup_sched: randomized bench for plane_setup_sched (4 attrs, latency 3, 32x32).
// Expected pixel order comes from a nested-loop tile model; timing from the sequencing rules.
module tb_plane_setup_sched;

    localparam int NA  = 4;
    localparam int LAT = 3;
    localparam int TW  = 32;
    localparam int TH  = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [10:0] tile_x_base = '0;
    logic [10:0] tile_y_base = '0;
    logic        abort = 1'b0;
    logic [1:0]  attr_sel;
    logic        coef_we;
    logic [1:0]  coef_idx;
    logic [10:0] x_ps;
    logic [10:0] y_ps;
    logic        px_valid;
    logic        px_ready = 1'b0;
    logic        span_last;
    logic        tile_done;
`ifdef PSS_PERF_EN
    logic [31:0] perf_tiles;
    logic [31:0] perf_stalls;
`endif

    plane_setup_sched #(
        .NUM_ATTR (NA),
        .SETUP_LAT(LAT),
        .TILE_W   (TW),
        .TILE_H   (TH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .tile_x_base(tile_x_base),
        .tile_y_base(tile_y_base),
        .abort      (abort),
        .attr_sel   (attr_sel),
        .coef_we    (coef_we),
        .coef_idx   (coef_idx),
        .x_ps       (x_ps),
        .y_ps       (y_ps),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .span_last  (span_last),
`ifdef PSS_PERF_EN
        .perf_tiles (perf_tiles),
        .perf_stalls(perf_stalls),
`endif
        .tile_done  (tile_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    int coef_k[$];
    int coef_i[$];
    int px_x[$];
    int px_y[$];
    int px_s[$];
    int npx, ndone, nbub, bub_err, hold_err, nstall;
    int first_px_k, done_k, abort_k, accepted, rdy_after;

    // Tile model: pixel i of a tile is row i/TW, column i%TW, both wrapping at 2048
    function automatic void model_px(input int xb, input int yb, input int i,
                                     output int ex, output int ey, output int es);
        ex = (xb + i % TW) % 2048;
        ey = (yb + i / TW) % 2048;
        es = (i % TW == TW - 1) ? 1 : 0;
    endfunction

    // Drives one triangle and records everything observed; no judging here
    task automatic run_triangle(input int xb, input int yb, input int pct,
                                input int nforce, input int abort_px);
        int k;
        int zrun;
        int forced;
        bit prev_stall;
        int lx, ly, ls;
        coef_k.delete(); coef_i.delete();
        px_x.delete(); px_y.delete(); px_s.delete();
        npx = 0; ndone = 0; nbub = 0; bub_err = 0; hold_err = 0; nstall = 0;
        first_px_k = -1; done_k = -1; abort_k = -1; accepted = 0; rdy_after = 0;
        forced = nforce; prev_stall = 0; zrun = 0; lx = 0; ly = 0; ls = 0;
        k = 0;
        while (k < 4000) begin
            @(negedge clock);
            tri_valid   = (k == 0);
            tile_x_base = 11'(xb);
            tile_y_base = 11'(yb);
            abort       = 1'b0;
            px_ready    = 1'b0;
            #1;
            if (k == 0) accepted = int'(tri_ready);
            if (px_valid) begin
                if (forced > 0) begin
                    px_ready = 1'b0;
                    forced--;
                end else begin
                    px_ready = ($urandom_range(99) < pct);
                end
                if (abort_px >= 0 && npx == abort_px && abort_k < 0) begin
                    abort   = 1'b1;
                    abort_k = k;
                end
            end else begin
                px_ready = 1'($urandom_range(1));
            end
            #1;
            if (coef_we) begin
                coef_k.push_back(k);
                coef_i.push_back(int'(coef_idx));
            end
            if (px_valid) begin
                if (prev_stall && (int'(x_ps) != lx || int'(y_ps) != ly ||
                                   int'(span_last) != ls))
                    hold_err++;
                if (first_px_k < 0) first_px_k = k;
                lx = int'(x_ps); ly = int'(y_ps); ls = int'(span_last);
                prev_stall = !px_ready;
                if (!px_ready) begin
                    nstall++;
                end else begin
                    px_x.push_back(lx);
                    px_y.push_back(ly);
                    px_s.push_back(ls);
                    npx++;
                end
                zrun = 0;
            end else begin
                prev_stall = 0;
                if (k > 0 && coef_k.size() == NA && !coef_we && !tile_done &&
                    !tri_ready && done_k < 0 && abort_k < 0) begin
                    nbub++;
                    zrun++;
                    if (zrun > 1) bub_err++;
                end
            end
            if (tile_done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (abort_k >= 0 && k == abort_k + 1) rdy_after = int'(tri_ready);
            if (done_k >= 0 && k == done_k + 1) begin
                rdy_after = int'(tri_ready);
                break;
            end
            if (abort_k >= 0 && k == abort_k + 4) break;
            k++;
        end
        tri_valid = 1'b0;
        abort     = 1'b0;
        px_ready  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if ({tri_ready, coef_we, coef_idx, attr_sel, x_ps, y_ps,
             px_valid, span_last, tile_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got tri_ready=%0b coef_we=%0b idx=%0d sel=%0d x=%0d y=%0d pv=%0b sl=%0b td=%0b want all 0",
                     tri_ready, coef_we, coef_idx, attr_sel, x_ps, y_ps,
                     px_valid, span_last, tile_done);
        end
`ifdef PSS_PERF_EN
        n_checks++;
        if (perf_tiles !== 32'd0 || perf_stalls !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", perf_tiles, perf_stalls);
        end
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        n_checks++;
        if (tri_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_tri_ready got %0b want 1", tri_ready);
        end
    endtask

    task automatic test_basic();
        int ex, ey, es, bad;
        run_triangle(0, 0, 100, 0, -1);
        n_checks++;
        if (accepted != 1) begin
            n_fail++;
            $display("FAIL basic_accept got %0d want 1", accepted);
        end
        for (int i = 0; i < NA; i++) begin
            n_checks++;
            if (i >= coef_k.size()) begin
                n_fail++;
                $display("FAIL basic_coef%0d got none want k=%0d", i, LAT * (i + 1));
            end else if (coef_k[i] != LAT * (i + 1) || coef_i[i] != i) begin
                n_fail++;
                $display("FAIL basic_coef%0d got k=%0d idx=%0d want k=%0d idx=%0d",
                         i, coef_k[i], coef_i[i], LAT * (i + 1), i);
            end
        end
        n_checks++;
        if (coef_k.size() != NA) begin
            n_fail++;
            $display("FAIL basic_coef_count got %0d want %0d", coef_k.size(), NA);
        end
        n_checks++;
        if (first_px_k != LAT * NA + 2) begin
            n_fail++;
            $display("FAIL basic_first_px got %0d want %0d", first_px_k, LAT * NA + 2);
        end
        n_checks++;
        if (npx != TW * TH) begin
            n_fail++;
            $display("FAIL basic_npx got %0d want %0d", npx, TW * TH);
        end
        n_checks++;
        if (nbub != TH || bub_err != 0) begin
            n_fail++;
            $display("FAIL basic_bubbles got %0d (long %0d) want %0d (long 0)",
                     nbub, bub_err, TH);
        end
        n_checks++;
        if (ndone != 1 || done_k != LAT * NA + 1 + TW * TH + TH) begin
            n_fail++;
            $display("FAIL basic_done got n=%0d k=%0d want n=1 k=%0d",
                     ndone, done_k, LAT * NA + 1 + TW * TH + TH);
        end
        n_checks++;
        if (rdy_after != 1) begin
            n_fail++;
            $display("FAIL basic_ready_after got %0d want 1", rdy_after);
        end
        bad = -1;
        for (int i = 0; i < px_x.size(); i++) begin
            model_px(0, 0, i, ex, ey, es);
            if (px_x[i] != ex || px_y[i] != ey || px_s[i] != es) begin
                bad = i;
                break;
            end
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL basic_pixels idx %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     bad, px_x[bad], px_y[bad], px_s[bad], ex, ey, es);
        end
    endtask

    task automatic test_backpressure();
        int ex, ey, es, bad, xb, yb;
        xb = int'($urandom_range(2047));
        yb = int'($urandom_range(2047));
        run_triangle(xb, yb, 60, 0, -1);
        n_checks++;
        if (hold_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold got %0d changes want 0", hold_err);
        end
        n_checks++;
        if (npx != TW * TH || ndone != 1) begin
            n_fail++;
            $display("FAIL bp_count got npx=%0d done=%0d want %0d/1", npx, ndone, TW * TH);
        end
        n_checks++;
        if (nbub != TH) begin
            n_fail++;
            $display("FAIL bp_bubbles got %0d want %0d", nbub, TH);
        end
        bad = -1;
        for (int i = 0; i < px_x.size(); i++) begin
            model_px(xb, yb, i, ex, ey, es);
            if (px_x[i] != ex || px_y[i] != ey || px_s[i] != es) begin
                bad = i;
                break;
            end
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL bp_pixels idx %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     bad, px_x[bad], px_y[bad], px_s[bad], ex, ey, es);
        end
    endtask

    task automatic test_wrap();
        int ex, ey, es, bad;
        run_triangle(2040, 2030, 100, 0, -1);
        n_checks++;
        if (npx != TW * TH) begin
            n_fail++;
            $display("FAIL wrap_npx got %0d want %0d", npx, TW * TH);
        end
        n_checks++;
        if (px_x.size() < TW * TH || px_x[7] != 2047 || px_x[8] != 0 ||
            px_x[TW - 1] != 23 || px_y[TW * TH - 1] != 13) begin
            n_fail++;
            $display("FAIL wrap_edges got x7=%0d x8=%0d x31=%0d ylast=%0d want 2047 0 23 13",
                     px_x[7], px_x[8], px_x[TW - 1], px_y[TW * TH - 1]);
        end
        bad = -1;
        for (int i = 0; i < px_x.size(); i++) begin
            model_px(2040, 2030, i, ex, ey, es);
            if (px_x[i] != ex || px_y[i] != ey || px_s[i] != es) begin
                bad = i;
                break;
            end
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL wrap_pixels idx %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     bad, px_x[bad], px_y[bad], px_s[bad], ex, ey, es);
        end
    endtask

    task automatic test_abort_walk();
        run_triangle(0, 0, 100, 0, 3 * TW + 5);
        n_checks++;
        if (npx != 3 * TW + 6 || ndone != 0) begin
            n_fail++;
            $display("FAIL abort_walk got npx=%0d done=%0d want %0d/0", npx, ndone, 3 * TW + 6);
        end
        n_checks++;
        if (px_x.size() < 3 * TW + 6 || px_x[3 * TW + 5] != 5 || px_y[3 * TW + 5] != 3) begin
            n_fail++;
            $display("FAIL abort_walk_px got size=%0d want (5,3) as last", px_x.size());
        end
        n_checks++;
        if (rdy_after != 1) begin
            n_fail++;
            $display("FAIL abort_walk_idle got %0d want 1", rdy_after);
        end
        run_triangle(0, 0, 100, 0, -1);
        n_checks++;
        if (coef_k.size() != NA || coef_k[0] != LAT || coef_i[0] != 0 || ndone != 1) begin
            n_fail++;
            $display("FAIL abort_restart got n=%0d k0=%0d i0=%0d done=%0d want %0d %0d 0 1",
                     coef_k.size(), coef_k[0], coef_i[0], ndone, NA, LAT);
        end
    endtask

    task automatic test_abort_setup();
        @(negedge clock);
        tri_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clock);
        tri_valid = 1'b0;
        abort     = 1'b0;
        #1;
        n_checks++;
        if (tri_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_accept got tri_ready=%0b want 0", tri_ready);
        end
        repeat (2) @(negedge clock);
        abort = 1'b1;
        #1;
        n_checks++;
        if (coef_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_coef_we got %0b want 0", coef_we);
        end
        @(negedge clock);
        abort = 1'b0;
        #1;
        n_checks++;
        if (tri_ready !== 1'b1 || coef_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_setup_idle got rdy=%0b we=%0b want 1 0", tri_ready, coef_we);
        end
    endtask

    task automatic test_reset_mid();
        int nwe, npv;
        @(negedge clock);
        tri_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            tri_valid = 1'b0;
            #1;
            if (k == 3) begin
                n_checks++;
                if (coef_we !== 1'b1 || coef_idx !== 2'd0) begin
                    n_fail++;
                    $display("FAIL rmid_first_coef got we=%0b idx=%0d want 1 0", coef_we, coef_idx);
                end
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (tri_ready !== 1'b0 || coef_we !== 1'b0 || attr_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_in_reset got rdy=%0b we=%0b sel=%0d want 0 0 0",
                     tri_ready, coef_we, attr_sel);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        nwe = 0;
        npv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            #1;
            if (coef_we) nwe++;
            if (px_valid) npv++;
        end
        n_checks++;
        if (nwe != 0 || npv != 0 || tri_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_after got we=%0d pv=%0d rdy=%0b want 0 0 1", nwe, npv, tri_ready);
        end
    endtask

`ifdef PSS_PERF_EN
    task automatic test_perf();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_triangle(0, 0, 100, 10, -1);
        #1;
        n_checks++;
        if (perf_tiles !== 32'd1 || perf_stalls !== 32'd10) begin
            n_fail++;
            $display("FAIL perf got tiles=%0d stalls=%0d want 1 10", perf_tiles, perf_stalls);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort_walk();
        test_abort_setup();
        test_reset_mid();
`ifdef PSS_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
